// File: rtl/mult_pkg.sv
// mult_pkg: shared constants for the long-latency ALU units (multiplier and divider).
//   MULT_WIDTH : operand width; products are 2*MULT_WIDTH bits
//   CNT_W      : width of the iteration counter
//   state_t    : IDLE=0, RUN=1, DONE=2 handshake FSM encoding
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_sign_fix.sv
// mult_sign_fix: sign handling wrapped around the unsigned shift-add core.
// Takes absolute values of the operands on entry. Conditionally negates the
// 2*WIDTH-bit product on exit.
//   i_a, i_b   : raw two's-complement operands
//   o_abs_a/b  : magnitudes. The most negative value maps to 2^(WIDTH-1) as unsigned.
//   o_neg      : result sign (a[msb] ^ b[msb]), to be latched with the operands
//   i_prod     : unsigned product from the core
//   i_neg      : latched result sign
//   o_prod     : signed product
import mult_pkg::*;

module mult_sign_fix #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH-1:0]   o_abs_a,
    output logic [WIDTH-1:0]   o_abs_b,
    output logic               o_neg,
    input  logic [2*WIDTH-1:0] i_prod,
    input  logic               i_neg,
    output logic [2*WIDTH-1:0] o_prod
);

    assign o_abs_a = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
    assign o_abs_b = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
    assign o_neg   = i_a[WIDTH-1] ^ i_b[WIDTH-1];
    assign o_prod  = i_neg ? (~i_prod + 1'b1) : i_prod;

endmodule

// File: rtl/sequential_multiplier.sv
// sequential_multiplier: radix-2 shift-add multiplier. It returns the full
// 2*WIDTH product as hi/lo. It shares its start/busy/done handshake with the
// sequential divider.
//   clock  : single clock, posedge
//   reset  : synchronous, active-high
//   start  : request, honoured only while idle. a/b are captured on that edge.
//   a, b   : multiplicand / multiplier
//   hi, lo : upper / lower half of the last completed product
//   busy   : high while iterating
//   done   : one-cycle pulse in the cycle hi/lo take a new result
// Optional build macro SEQ_MULT_SIGNED_EN: treat a/b as two's complement.
// Operand magnitudes are multiplied and the result is negated on the write
// edge. Latency is the same as the unsigned build.
import mult_pkg::*;

module sequential_multiplier #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    state_t             w_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [2*WIDTH-1:0] w_result;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_count == CNT_W'(WIDTH - 1));

    // The accumulator shifts right each step, so the multiplicand is always
    // added into the top half. That is equivalent to acc += a << count, but
    // it needs only a WIDTH+1 adder. The carry re-enters as the new MSB.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_step = {w_sum, r_acc[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;
    logic w_neg;

    mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_a     (a),
        .i_b     (b),
        .o_abs_a (w_op_a),
        .o_abs_b (w_op_b),
        .o_neg   (w_neg),
        .i_prod  (w_step),
        .i_neg   (r_neg),
        .o_prod  (w_result)
    );

    always_ff @(posedge clock) begin
        if (reset)         r_neg <= 1'b0;
        else if (w_accept) r_neg <= w_neg;
    end
`else
    assign w_op_a   = a;
    assign w_op_b   = b;
    assign w_result = w_step;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath. hi/lo are written only on the last iteration, so they never
    // expose partial sums.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mcand  <= w_op_a;
                r_mplier <= w_op_b;
                r_acc    <= '0;
                r_count  <= '0;
            end else if (r_state == RUN) begin
                r_acc    <= w_step;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CNT_W'(1);
                if (w_last) begin
                    r_hi   <= w_result[2*WIDTH-1:WIDTH];
                    r_lo   <= w_result[WIDTH-1:0];
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state == RUN);
    assign done = r_done;

endmodule
